// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [CW-1:0] code);
        return N'(1) << code;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first set bit of (req & mask) at or after ptr, wrapping 7->0.
module rr_priority_pick
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          any,
    output logic [CW-1:0] win_code
);

    logic [N-1:0]  masked;
    logic [N-1:0]  rot;
    logic [CW-1:0] idx;

    // Rotate right by ptr so the highest-priority requester lands at bit 0.
    always_comb begin
        masked = req & mask;
        rot    = '0;
        for (int i = 0; i < int'(N); i++) begin
            rot[i] = masked[CW'(i) + ptr];
        end
    end

    always_comb begin
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) idx = CW'(i);
        end
    end

    assign any      = |rot;
    assign win_code = idx + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time and registered grant outputs.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HW       = 8
) (
    input  logic          clock,
    input  logic          reset_b,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] grant_code,
    output logic          busy,
    output logic          timeout
);

    state_e        state_q, state_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] code_q, code_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic [CW-1:0] pick_ptr;
    logic [N-1:0]  pick_mask;
    logic          pick_any;
    logic [CW-1:0] pick_code;
    logic          owner_req;
    logic          limit_hit;

    // While granting, the next owner is searched from owner+1 with the owner excluded.
    always_comb begin
        pick_ptr  = ptr_q;
        pick_mask = '1;
        if (state_q == GRANT) begin
            pick_ptr  = code_q + CW'(1);
            pick_mask = ~onehot(code_q);
        end
    end

    rr_priority_pick u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask     (pick_mask),
        .any      (pick_any),
        .win_code (pick_code)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            code_q     <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        code_d     = code_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        owner_req  = req[code_q];
        limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_d    = onehot(pick_code);
                    code_d     = pick_code;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    grant_d = '0;
                    code_d  = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (owner_req && !limit_hit) begin
                    if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HW'(1);
                end else begin
                    // Release or forced preemption: hand over without a bubble when possible.
                    ptr_d      = code_q + CW'(1);
                    timeout_d  = owner_req;
                    hold_cnt_d = '0;
                    if (pick_any) begin
                        grant_d = onehot(pick_code);
                        code_d  = pick_code;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        code_d  = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                code_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant      = grant_q;
    assign grant_code = code_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: reference model pushes per-cycle expectations, monitor compares.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clock = 1'b0;
    logic       reset_b = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_code;
    logic       busy;
    logic       timeout;

    rr_arbiter8 #(.MAX_HOLD(MH), .HW(8)) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .req        (req),
        .grant      (grant),
        .grant_code (grant_code),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected {timeout, busy, grant_code, grant} per cycle.
    logic [12:0] exp_q[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t act=%h exp=%h (to,busy,code,grant)", name, $time, act, exp);
    endtask

    function automatic int pick(input logic [7:0] r, input int start, input int excl);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    // Reference model: owner index, priority pointer and number of cycles granted so far.
    always @(posedge clock) begin
        logic       to;
        logic [7:0] g;
        logic [2:0] c;
        to = 1'b0;
        if (!reset_b) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(req, m_ptr, -1);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else if (req[m_owner] && !(MH != 0 && m_held == MH)) begin
            m_held++;
        end else begin
            to      = req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = pick(req, m_ptr, m_owner);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end
        g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        c = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        exp_q.push_back({to, (m_owner >= 0), c, g});
    end

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            chk("cycle", {timeout, busy, grant_code, grant}, e);
        end
    end

    task automatic drive(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            req = r;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_b = 1'b0;
        req     = 8'h00;
        repeat (2) @(negedge clock);
        reset_b = 1'b1;
    endtask

    initial begin
        logic [7:0] rr;
        repeat (3) @(negedge clock);
        reset_b = 1'b1;

        // Single requester, then release.
        drive(8'h04, 3);
        drive(8'h00, 2);
        // ptr now 3: requests 2 and 4 together must go to 4 first.
        drive(8'h14, 1);
        drive(8'h00, 2);

        // Alternation between 0 and 7 with no idle gap.
        do_reset();
        drive(8'h81, 2);
        drive(8'h80, 1);
        drive(8'h81, 1);
        drive(8'h01, 1);
        drive(8'h81, 1);
        drive(8'h80, 1);
        drive(8'h81, 1);
        drive(8'h01, 1);
        drive(8'h00, 2);

        // Owner 5 releases (ptr=6); requests 1 and 5 -> wrap to 1.
        drive(8'h20, 2);
        drive(8'h00, 1);
        drive(8'h22, 3);
        drive(8'h00, 2);

        // Preemption between 3 and 6, then 6 alone handing back to 3.
        do_reset();
        drive(8'h48, 12);
        drive(8'h40, 2);
        drive(8'h08, 3);
        drive(8'h00, 2);

        // Lone requester repeatedly preempted with one idle cycle between grants.
        drive(8'h01, 16);
        drive(8'h00, 2);

        // Asynchronous reset mid-grant to owner 4.
        drive(8'h10, 3);
        #2;
        reset_b = 1'b0;
        #1;
        chk("async_reset", {timeout, busy, grant_code, grant}, 13'h0);
        @(negedge clock);
        req     = 8'hFF;
        reset_b = 1'b1;
        drive(8'hFF, 6);
        drive(8'h00, 2);

        // Randomised request toggling.
        rr = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            end
            if ($urandom_range(0, 99) == 0) rr = 8'h00;
            req = rr;
        end
        drive(8'h00, 3);

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
